// File: rtl/nibbler_pkg.sv
// Shared types and default widths for the nibbler RAM subsystem.
// Holds the arbiter state encoding and the bus/burst defaults.
package nibbler_pkg;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 4;
   localparam int BURST_MAX = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous RAM.
// Port 0 is the CPU, port 1 the loader/DMA; bursts are capped under contention.
module ram_arbiter #(
   parameter int ADDR_W    = nibbler_pkg::ADDR_W,
   parameter int DATA_W    = nibbler_pkg::DATA_W,
   parameter int BURST_MAX = nibbler_pkg::BURST_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   import nibbler_pkg::*;

   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

   arb_state_t       state;
   arb_state_t       state_next;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             last;
   logic             acc0;
   logic             acc1;
   logic             acc;
   logic             at_limit;
   logic             switching;

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   // Reset gates the accept terms so the RAM is never selected during reset.
   assign acc0 = ~reset & req0 & gnt0;
   assign acc1 = ~reset & req1 & gnt1;
   assign acc  = acc0 | acc1;

   assign ram_cs = acc;

   // Saturating view of the count including this edge's transfer.
   always_comb begin
      cnt_next = burst_cnt;
      if (acc && (burst_cnt != CNT_MAX))
         cnt_next = burst_cnt + 1'b1;
   end

   // The grant yields on the edge that completes its BURST_MAX-th transfer.
   assign at_limit  = (cnt_next == CNT_MAX);
   assign switching = (state_next != state);

   // Steer the granted port onto the RAM bus; zero when nothing is selected.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (1'b1)
         acc0: begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
         end
         acc1: begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
         end
         default: begin
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
         end
      endcase
   end

   // Next-state logic: round-robin from IDLE, handover on drop or burst cap.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (req0 && req1)
               state_next = last ? GNT0 : GNT1;
            else if (req0)
               state_next = GNT0;
            else if (req1)
               state_next = GNT1;
         end
         GNT0: begin
            if (!req0)
               state_next = req1 ? GNT1 : IDLE;
            else if (req1 && at_limit)
               state_next = GNT1;
         end
         GNT1: begin
            if (!req1)
               state_next = req0 ? GNT0 : IDLE;
            else if (req0 && at_limit)
               state_next = GNT0;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, burst counter and last-served pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= '0;
         last      <= 1'b1;
      end else begin
         state     <= state_next;
         burst_cnt <= switching ? '0 : cnt_next;
         if (switching && (state_next == GNT0))
            last <= 1'b0;
         else if (switching && (state_next == GNT1))
            last <= 1'b1;
      end
   end

   // Reads return one cycle later, tagged to the port that issued them.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= acc0 & ~we0;
         rvalid1 <= acc1 & ~we1;
      end
   end

   assign rdata = (rvalid0 | rvalid1) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural synchronous RAM.
// Reads push expected data; a negedge monitor pops on every rvalid.
module tb_ram_arbiter;

   localparam int AW = 12;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic          ram_cs, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: write on select+we, read data one cycle later.
   always @(posedge clk) begin
      if (ram_cs && ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= (ram_cs && !ram_we) ? mem[ram_addr] : '0;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic expect_read(input logic port, input logic [DW-1:0] d);
      exp_t e;
      e.port = port;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_out();
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
   endtask

   // Monitor: grant exclusivity, rvalid against scoreboard, idle rdata.
   always @(negedge clk) begin
      exp_t e;
      check("gnt_exclusive", int'(gnt0 & gnt1), 0);
      if (rvalid0 || rvalid1) begin
         if (exp_q.size() == 0) begin
            check("rvalid_unexpected", int'({rvalid1, rvalid0}), 0);
         end else begin
            e = exp_q.pop_front();
            check("rvalid_both", int'(rvalid0 & rvalid1), 0);
            check("rvalid_port", int'(rvalid1), int'(e.port));
            check("rdata", int'(rdata), int'(e.data));
         end
      end else begin
         check("rdata_idle", int'(rdata), 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset  = 1'b1;
      req0   = 1'b0;
      req1   = 1'b0;
      we0    = 1'b0;
      we1    = 1'b0;
      addr0  = '0;
      addr1  = '0;
      wdata0 = '0;
      wdata1 = '0;

      // Reset state
      tick();
      tick();
      smp();
      check("rst_gnt0", int'(gnt0), 0);
      check("rst_gnt1", int'(gnt1), 0);
      check("rst_rvalid", int'({rvalid1, rvalid0}), 0);
      check("rst_ram_cs", int'(ram_cs), 0);
      tick();
      reset = 1'b0;

      // Write 0xA to 0x005, then read it back
      req0   = 1'b1;
      we0    = 1'b1;
      addr0  = 12'h005;
      wdata0 = 4'hA;
      smp();
      check("s1_gnt0_latency", int'(gnt0), 0);
      tick();
      smp();
      check("s1_gnt0", int'(gnt0), 1);
      check("s1_cs", int'(ram_cs), 1);
      check("s1_we", int'(ram_we), 1);
      check("s1_addr", int'(ram_addr), 'h005);
      check("s1_wdata", int'(ram_wdata), 'hA);
      tick();
      we0 = 1'b0;
      expect_read(1'b0, 4'hA);
      smp();
      check("s1_rd_we", int'(ram_we), 0);
      check("s1_rd_cs", int'(ram_cs), 1);
      tick();
      req0 = 1'b0;
      smp();
      check("s1_rvalid0", int'(rvalid0), 1);
      check("s1_rdata", int'(rdata), 'hA);
      check("s1_cs_off", int'(ram_cs), 0);
      check("s1_addr_zero", int'(ram_addr), 0);
      tick();
      smp();
      check("s1_idle", int'(gnt0), 0);

      // Tie after reset: port 0 first, 4-transfer bursts alternate
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      req0   = 1'b1;
      req1   = 1'b1;
      we0    = 1'b1;
      we1    = 1'b1;
      addr0  = 12'h010;
      addr1  = 12'h020;
      wdata0 = 4'h1;
      wdata1 = 4'h2;
      for (int i = 1; i <= 9; i++) begin
         tick();
         smp();
         check($sformatf("s2_gnt0_c%0d", i), int'(gnt0),
               (i <= 4 || i == 9) ? 1 : 0);
         check($sformatf("s2_gnt1_c%0d", i), int'(gnt1),
               (i >= 5 && i <= 8) ? 1 : 0);
      end
      tick();
      idle_out();

      // Port 1 alone for 10 cycles: no handover, then saturated switch
      req1  = 1'b1;
      we1   = 1'b1;
      addr1 = 12'h030;
      n = 0;
      tick();
      for (int i = 1; i <= 10; i++) begin
         smp();
         check($sformatf("s3_gnt1_c%0d", i), int'(gnt1), 1);
         if (ram_cs && gnt1)
            n++;
         tick();
      end
      check("s3_accepts", n, 10);
      req0 = 1'b1;
      we0  = 1'b1;
      tick();
      smp();
      check("s3_sat_gnt0", int'(gnt0), 1);
      check("s3_sat_gnt1", int'(gnt1), 0);
      idle_out();

      // Port-0 read accepted on the handover edge
      req0  = 1'b1;
      we0   = 1'b0;
      addr0 = 12'h005;
      tick();
      for (int i = 0; i < 4; i++)
         expect_read(1'b0, 4'hA);
      req1  = 1'b1;
      we1   = 1'b1;
      addr1 = 12'h040;
      smp();
      check("s4_gnt0", int'(gnt0), 1);
      tick();
      tick();
      tick();
      tick();
      req0 = 1'b0;
      smp();
      check("s4_gnt1", int'(gnt1), 1);
      check("s4_gnt0_off", int'(gnt0), 0);
      check("s4_rvalid0", int'(rvalid0), 1);
      check("s4_rvalid1", int'(rvalid1), 0);
      check("s4_rdata", int'(rdata), 'hA);
      idle_out();

      // Reset the cycle after a read is accepted
      req0  = 1'b1;
      we0   = 1'b0;
      addr0 = 12'h005;
      expect_read(1'b0, 4'hA);
      tick();
      tick();
      reset = 1'b1;
      smp();
      check("s5_cs_in_reset", int'(ram_cs), 0);
      check("s5_rvalid0_pre", int'(rvalid0), 1);
      tick();
      reset = 1'b0;
      req0  = 1'b0;
      smp();
      check("s5_rvalid0", int'(rvalid0), 0);
      check("s5_gnt0", int'(gnt0), 0);
      check("s5_gnt1", int'(gnt1), 0);

      // Pointer restored by reset; req0 drops while req1 waits
      req0 = 1'b1;
      req1 = 1'b1;
      we0  = 1'b1;
      we1  = 1'b1;
      tick();
      smp();
      check("s6_tie_gnt0", int'(gnt0), 1);
      tick();
      req0 = 1'b0;
      smp();
      check("s6_hold_gnt0", int'(gnt0), 1);
      tick();
      smp();
      check("s6_direct_gnt1", int'(gnt1), 1);
      check("s6_direct_gnt0", int'(gnt0), 0);
      idle_out();

      tick();
      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
